// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core/DMA) arbiter and sequencer for a 64-bit access data memory
module dmem_arbiter #(
  parameter int MEM_BYTES  = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wdata,
  output logic [63:0] core_rdata,
  output logic        core_done,
  output logic        core_err,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  output logic [63:0] dma_rdata,
  output logic        dma_done,
  output logic        dma_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [63:0] AMAX = 64'(MEM_BYTES - 8);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          grant, dma_win, in_range, acc, resp;

  assign acc      = state_q == ACCESS;
  assign resp     = state_q == RESP;
  assign grant    = state_q == IDLE && (core_req || dma_req);
  assign dma_win  = dma_req && (!core_req || starve_q == SMAX);
  // full-width compare so huge addresses never alias into the array
  assign in_range = addr_q <= AMAX;

  always_comb begin
    state_d  = grant ? ACCESS : acc ? RESP : IDLE;
    owner_d  = grant ? dma_win : owner_q;
    we_d     = grant ? (dma_win ? dma_we : core_we) : we_q;
    addr_d   = grant ? (dma_win ? dma_addr : core_addr) : addr_q;
    wdata_d  = grant ? (dma_win ? dma_wdata : core_wdata) : wdata_q;
    starve_d = !grant ? starve_q : (dma_win || !dma_req) ? '0 :
               starve_q == SMAX ? starve_q : starve_q + SW'(1);
    err_d    = acc ? !in_range : err_q;
    rdata_d  = acc ? ((in_range && !we_q) ? Read_Data : '0) : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign Mem_Addr   = acc ? addr_q : '0;
  assign Write_Data = acc ? wdata_q : '0;
  assign MemWrite   = acc && in_range && we_q;
  assign MemRead    = acc && in_range && !we_q;

  assign core_done  = resp && !owner_q;
  assign core_err   = core_done && err_q;
  assign core_rdata = core_done ? rdata_q : '0;
  assign core_stall = core_req && !core_done;
  assign dma_done   = resp && owner_q;
  assign dma_err    = dma_done && err_q;
  assign dma_rdata  = dma_done ? rdata_q : '0;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 256-byte, byte-addressed, little-endian data memory. Shares it between the pipeline MEM stage (core port) and a loader/debug DMA port. Each granted request becomes exactly one 64-bit access on the memory's Mem_Addr/Write_Data/MemWrite/MemRead/Read_Data interface. The block also performs bounds checking and stalls the pipeline while the core request is outstanding.

## Interface
Parameters:
- MEM_BYTES, 256: memory size in bytes; legal addresses are 0..MEM_BYTES-8.
- STARVE_MAX, 4: consecutive core grants allowed while DMA waits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held with fields stable until core_done.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  64  byte address.
- core_wdata  in  64  store data.
- core_rdata  out  64  load data, valid while core_done = 1.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  out-of-range flag, valid with core_done.
- core_stall  out  1  core_req & ~core_done (combinational).
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done, dma_err: same as the core_* signals, for the DMA port.
- Mem_Addr  out  64  to memory.
- Write_Data  out  64  to memory.
- MemWrite  out  1  to memory; memory writes on the rising edge ending the cycle.
- MemRead  out  1  to memory.
- Read_Data  in  64  from memory; combinational read.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise choose an owner: core wins unless dma_req = 1 and starve_cnt == STARVE_MAX, in which case DMA wins.
  - Latch owner, we, addr and wdata into registers. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive Mem_Addr and Write_Data from the latched registers.
  - In range (addr <= MEM_BYTES-8): MemWrite = we, MemRead = ~we.
  - Out of range: MemWrite = MemRead = 0 and err_r is set.
  - Loads capture Read_Data into rdata_r; stores and errors set rdata_r = 0.
  - Go to RESP.
- RESP (1 cycle):
  - Assert the owner's done pulse; err and rdata come from registers.
  - The non-owner's done, err and rdata stay 0.
  - Go to IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)), updated on the IDLE→ACCESS transition:
  - Core granted while dma_req = 1: increment, saturating at STARVE_MAX.
  - DMA granted: clear to 0.
  - Core granted while dma_req = 0: clear to 0.
- Outside ACCESS, Mem_Addr, Write_Data, MemWrite and MemRead are all 0.
- A requester deasserts req in the cycle its done is high. The arbiter samples req only in IDLE, so there is no double grant.
- Dropping req before done is illegal. Once latched, the access still completes and done is still pulsed.
- Out-of-range check uses the full 64-bit compare. An address such as 0xFFFF_FFFF_FFFF_FFFF is an error, not a wrap-around.

## Timing
- Request seen in IDLE at edge k:
  - ACCESS during cycle k+1.
  - Store committed at edge k+2.
  - done, rdata and err high during cycle k+2.
  - IDLE again in cycle k+3.
- Throughput: one access per 3 cycles. Back-to-back requests: the next ACCESS starts in the cycle after the next IDLE.
- core_stall covers every cycle from core_req rising through the cycle before core_done, i.e. 2 cycles minimum.
- Reset values: state = IDLE, starve_cnt = 0, all latched registers 0, every output 0 (core_stall = core_req).
- Reset asserted during ACCESS:
  - A store already on MemWrite that cycle commits at that edge.
  - No done is issued. The requester must re-request.
- Reset asserted during RESP: done is still visible in that cycle (registered), then everything clears.

## Test plan
- Core load, addr 0x10, mem[16..23] = 0x04: core_done in cycle 3 with core_rdata = 0x0000_0000_0000_0004. MemRead high only in cycle 2. core_stall high in cycles 1-2.
- Core store, addr 0x20, wdata 0x1122_3344_5566_7788, then core load of 0x20: the load returns 0x1122_3344_5566_7788. MemWrite high exactly 1 cycle.
- Both ports request continuously from reset with STARVE_MAX = 4: grant order is C, C, C, C, D, C, C, C, C, D. dma_done is never delayed more than 5 grants.
- Out-of-range core load at addr 0xF9 (MEM_BYTES = 256): MemRead and MemWrite stay 0, core_err = 1 with core_done, core_rdata = 0. A subsequent legal load at 0xF8 has err = 0.
- DMA store accepted, reset pulsed during its ACCESS cycle: no dma_done, all outputs 0 in the following cycle, starve_cnt = 0. A memory readback of that address shows the new data.
